// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius game controller: state encodings,
// default parameters and the width helper.
package genius_pkg;

  typedef enum logic [3:0] {
    ST_INIT       = 4'd0,
    ST_SETUP      = 4'd1,
    ST_PLAY_FPGA  = 4'd2,
    ST_PLAY_USER  = 4'd3,
    ST_CHECK      = 4'd4,
    ST_NEXT_ROUND = 4'd5,
    ST_RETRY      = 4'd6,
    ST_RESULT     = 4'd7
  } state_t;

  localparam int DEF_NROUNDS     = 32;
  localparam int DEF_TIMEOUT_CYC = 50000000;
  localparam int DEF_LIVES       = 3;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/genius_timer.sv
// Idle-time counter for the user phase: fires after TIMEOUT_CYC consecutive
// enabled cycles without a clear.
module genius_timer
  import genius_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int TW = clog2(TIMEOUT_CYC)
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fire
);

  logic [TW-1:0] count_q;

  assign fire = en && !clr && (count_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLOCK) begin
    if (reset || clr || fire) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + TW'(1);
    end
  end

endmodule

// File: rtl/genius_ctrl_p.sv
// Genius (Simon) game control FSM with Moore outputs and user timeout.
// Define GENIUS_LIVES_EN to allow LIVES failures with sequence replay before game over.
module genius_ctrl_p
  import genius_pkg::*;
#(
  parameter int NROUNDS     = DEF_NROUNDS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int LIVES       = DEF_LIVES,
  localparam int RW = clog2(NROUNDS + 1),
  localparam int LW = clog2(LIVES + 1)
) (
  input  logic          CLOCK,
  input  logic          reset,
  input  logic          enter,
  input  logic          end_FPGA,
  input  logic          end_User,
  input  logic          key_any,
  input  logic          match,
  output logic          R1,
  output logic          R2,
  output logic          E1,
  output logic          E2,
  output logic          E3,
  output logic          E4,
  output logic          SEL,
  output logic [RW-1:0] round,
  output logic [LW-1:0] lives,
  output logic          win,
  output logic          timeout,
  output logic [3:0]    state_o
);

`ifdef GENIUS_LIVES_EN
  localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
`else
  localparam logic [LW-1:0] LIVES_INIT = '0;
`endif

  state_t        state_q, state_n;
  logic [RW-1:0] round_n;
  logic [LW-1:0] lives_n;
  logic          win_n;
  logic          fail;
  logic          tmr_clr, tmr_en, tmr_fire;

  // {R1, R2, E1, E2, E3, E4, SEL}
  function automatic logic [6:0] decode(input state_t s);
    case (s)
      ST_INIT:       return 7'b1100000;
      ST_SETUP:      return 7'b0010000;
      ST_PLAY_FPGA:  return 7'b0000100;
      ST_PLAY_USER:  return 7'b0001000;
      ST_CHECK:      return 7'b0000010;
      ST_NEXT_ROUND: return 7'b0100000;
      ST_RETRY:      return 7'b0100000;
      ST_RESULT:     return 7'b0000001;
      default:       return 7'b0000000;
    endcase
  endfunction

  // Counter is held at zero outside Play_User, so it starts clean on every entry.
  assign tmr_en  = (state_q == ST_PLAY_USER);
  assign tmr_clr = key_any || (state_q != ST_PLAY_USER);

  genius_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .CLOCK (CLOCK),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .fire  (tmr_fire)
  );

  always_comb begin
    state_n = state_q;
    round_n = round;
    lives_n = lives;
    win_n   = win;
    fail    = 1'b0;
    case (state_q)
      ST_INIT: begin
        state_n = ST_SETUP;
        round_n = RW'(1);
        lives_n = LIVES_INIT;
        win_n   = 1'b0;
      end
      ST_SETUP:     if (enter) state_n = ST_PLAY_FPGA;
      ST_PLAY_FPGA: if (end_FPGA) state_n = ST_PLAY_USER;
      ST_PLAY_USER: begin
        if (tmr_fire)      fail    = 1'b1;
        else if (end_User) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (match) state_n = ST_NEXT_ROUND;
        else       fail    = 1'b1;
      end
      ST_NEXT_ROUND: begin
        if (round >= RW'(NROUNDS)) begin
          state_n = ST_RESULT;
          win_n   = 1'b1;
        end else begin
          round_n = round + RW'(1);
          state_n = ST_PLAY_FPGA;
        end
      end
      ST_RETRY: state_n = ST_PLAY_FPGA;
      ST_RESULT: begin
        if (enter) begin
          state_n = ST_INIT;
          round_n = RW'(1);
          lives_n = LIVES_INIT;
          win_n   = 1'b0;
        end
      end
      default: state_n = ST_INIT;
    endcase

    if (fail) begin
`ifdef GENIUS_LIVES_EN
      if (lives > LW'(1)) begin
        lives_n = lives - LW'(1);
        state_n = ST_RETRY;
      end else begin
        lives_n = '0;
        state_n = ST_RESULT;
        win_n   = 1'b0;
      end
`else
      state_n = ST_RESULT;
      win_n   = 1'b0;
`endif
    end
  end

  // Outputs are registered from the next state so they always match state_q.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q <= ST_INIT;
      round   <= RW'(1);
      lives   <= LIVES_INIT;
      win     <= 1'b0;
      timeout <= 1'b0;
      {R1, R2, E1, E2, E3, E4, SEL} <= decode(ST_INIT);
    end else begin
      state_q <= state_n;
      round   <= round_n;
      lives   <= lives_n;
      win     <= win_n;
      timeout <= tmr_fire;
      {R1, R2, E1, E2, E3, E4, SEL} <= decode(state_n);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_genius_ctrl_p.sv
// Directed bench for genius_ctrl_p (NROUNDS=3, TIMEOUT_CYC=16, LIVES=2); follows GENIUS_LIVES_EN.
module tb_genius_ctrl_p;
  import genius_pkg::*;

  localparam logic [4:0] I_NONE  = 5'b00000;
  localparam logic [4:0] I_ENTER = 5'b10000;
  localparam logic [4:0] I_EFPGA = 5'b01000;
  localparam logic [4:0] I_EUSER = 5'b00100;
  localparam logic [4:0] I_KEY   = 5'b00010;
  localparam logic [4:0] I_MATCH = 5'b00001;

`ifdef GENIUS_LIVES_EN
  localparam state_t ST_MISS = ST_RETRY;
`else
  localparam state_t ST_MISS = ST_RESULT;
`endif

  logic       CLOCK, reset, enter, end_FPGA, end_User, key_any, match;
  logic       R1, R2, E1, E2, E3, E4, SEL, win, timeout;
  logic [1:0] round, lives;
  logic [3:0] state_o;
  logic [6:0] outs;

  int n_vec = 0;
  int n_bad = 0;

  assign outs = {R1, R2, E1, E2, E3, E4, SEL};

  genius_ctrl_p #(.NROUNDS(3), .TIMEOUT_CYC(16), .LIVES(2)) dut (
    .CLOCK(CLOCK), .reset(reset), .enter(enter), .end_FPGA(end_FPGA),
    .end_User(end_User), .key_any(key_any), .match(match),
    .R1(R1), .R2(R2), .E1(E1), .E2(E2), .E3(E3), .E4(E4), .SEL(SEL),
    .round(round), .lives(lives), .win(win), .timeout(timeout), .state_o(state_o)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [4:0] in;
    state_t     st;
    int         rnd;
    int         lv;
    int         w;
    bit         to;
  } vec_t;

  vec_t tbl[19];

  // {R1, R2, E1, E2, E3, E4, SEL} expected in each state
  function automatic logic [6:0] exp_outs(input state_t s);
    case (s)
      ST_INIT:       return 7'b1100000;
      ST_SETUP:      return 7'b0010000;
      ST_PLAY_FPGA:  return 7'b0000100;
      ST_PLAY_USER:  return 7'b0001000;
      ST_CHECK:      return 7'b0000010;
      ST_NEXT_ROUND: return 7'b0100000;
      ST_RETRY:      return 7'b0100000;
      ST_RESULT:     return 7'b0000001;
      default:       return 7'b0000000;
    endcase
  endfunction

  function automatic int lx(input int v);
`ifdef GENIUS_LIVES_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic step(input logic [4:0] v);
    {enter, end_FPGA, end_User, key_any, match} = v;
    @(posedge CLOCK);
    #1;
  endtask

  // rnd / w of -1 mean "not checked"
  task automatic chk(input string nm, input state_t st, input int rnd, input int lv,
                     input int w, input bit to);
    logic [6:0] eo;
    int         elv;
    eo  = exp_outs(st);
    elv = lx(lv);
    n_vec++;
    if (state_o !== st || outs !== eo || (rnd >= 0 && round !== 2'(rnd)) ||
        lives !== 2'(elv) || (w >= 0 && win !== 1'(w)) || timeout !== to) begin
      n_bad++;
      $display("FAIL %s: got state=%0d outs=%b round=%0d lives=%0d win=%b timeout=%b; want state=%0d outs=%b round=%0d lives=%0d win=%0d timeout=%b",
               nm, state_o, outs, round, lives, win, timeout, st, eo, rnd, elv, w, to);
    end
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    {enter, end_FPGA, end_User, key_any, match} = I_NONE;
    @(posedge CLOCK);
    #1;
    reset = 1'b0;
    chk(nm, ST_INIT, 1, 2, 0, 1'b0);
  endtask

  task automatic goto_play_user(input string nm);
    do_reset({nm, ".rst"});
    step(I_NONE);  chk({nm, ".setup"}, ST_SETUP, 1, 2, -1, 1'b0);
    step(I_ENTER); chk({nm, ".fpga"}, ST_PLAY_FPGA, 1, 2, -1, 1'b0);
    step(I_EFPGA); chk({nm, ".user"}, ST_PLAY_USER, 1, 2, -1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{I_NONE,  ST_SETUP,      1,  2, -1, 1'b0};
    tbl[1]  = '{I_NONE,  ST_SETUP,      1,  2, -1, 1'b0};
    tbl[2]  = '{I_ENTER, ST_PLAY_FPGA,  1,  2, -1, 1'b0};
    tbl[3]  = '{I_NONE,  ST_PLAY_FPGA,  1,  2, -1, 1'b0};
    tbl[4]  = '{I_EFPGA, ST_PLAY_USER,  1,  2, -1, 1'b0};
    tbl[5]  = '{I_EUSER, ST_CHECK,      1,  2, -1, 1'b0};
    tbl[6]  = '{I_MATCH, ST_NEXT_ROUND, 1,  2, -1, 1'b0};
    tbl[7]  = '{I_NONE,  ST_PLAY_FPGA,  2,  2, -1, 1'b0};
    tbl[8]  = '{I_EFPGA, ST_PLAY_USER,  2,  2, -1, 1'b0};
    tbl[9]  = '{I_EUSER, ST_CHECK,      2,  2, -1, 1'b0};
    tbl[10] = '{I_MATCH, ST_NEXT_ROUND, 2,  2, -1, 1'b0};
    tbl[11] = '{I_NONE,  ST_PLAY_FPGA,  3,  2, -1, 1'b0};
    tbl[12] = '{I_EFPGA, ST_PLAY_USER,  3,  2, -1, 1'b0};
    tbl[13] = '{I_EUSER, ST_CHECK,      3,  2, -1, 1'b0};
    tbl[14] = '{I_MATCH, ST_NEXT_ROUND, 3,  2, -1, 1'b0};
    tbl[15] = '{I_NONE,  ST_RESULT,     3,  2,  1, 1'b0};
    tbl[16] = '{I_NONE,  ST_RESULT,     3,  2,  1, 1'b0};
    tbl[17] = '{I_ENTER, ST_INIT,      -1,  2, -1, 1'b0};
    tbl[18] = '{I_NONE,  ST_SETUP,      1,  2, -1, 1'b0};

    reset = 1'b1;
    {enter, end_FPGA, end_User, key_any, match} = I_NONE;
    @(posedge CLOCK);
    do_reset("reset");

    // Perfect game, then restart from Result
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].in);
      chk($sformatf("game[%0d]", i), tbl[i].st, tbl[i].rnd, tbl[i].lv, tbl[i].w, tbl[i].to);
    end

    // Timeout after 16 idle Play_User cycles
    goto_play_user("tmo");
    for (int i = 0; i < 15; i++) begin
      step(I_NONE);
      chk($sformatf("tmo.wait[%0d]", i), ST_PLAY_USER, 1, 2, -1, 1'b0);
    end
    step(I_NONE); chk("tmo.fire", ST_MISS, 1, 1, -1, 1'b1);
`ifdef GENIUS_LIVES_EN
    step(I_NONE);  chk("tmo.replay", ST_PLAY_FPGA, 1, 1, -1, 1'b0);
    step(I_EFPGA); chk("tmo.user2", ST_PLAY_USER, 1, 1, -1, 1'b0);
`else
    step(I_NONE);  chk("tmo.hold", ST_RESULT, 1, 0, 0, 1'b0);
`endif

    // end_User on the firing cycle: the fail path wins
    goto_play_user("sim");
    for (int i = 0; i < 15; i++) begin
      step(I_NONE);
      chk($sformatf("sim.wait[%0d]", i), ST_PLAY_USER, 1, 2, -1, 1'b0);
    end
    step(I_EUSER); chk("sim.fire", ST_MISS, 1, 1, -1, 1'b1);

    // key_any at count 14 restarts the full 16-cycle window
    goto_play_user("key");
    for (int i = 0; i < 14; i++) begin
      step(I_NONE);
      chk($sformatf("key.pre[%0d]", i), ST_PLAY_USER, 1, 2, -1, 1'b0);
    end
    step(I_KEY); chk("key.press", ST_PLAY_USER, 1, 2, -1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(I_NONE);
      chk($sformatf("key.post[%0d]", i), ST_PLAY_USER, 1, 2, -1, 1'b0);
    end
    step(I_NONE); chk("key.fire", ST_MISS, 1, 1, -1, 1'b1);

    // Mismatches until game over
    goto_play_user("mis");
    step(I_EUSER); chk("mis.check1", ST_CHECK, 1, 2, -1, 1'b0);
    step(I_NONE);  chk("mis.miss1", ST_MISS, 1, 1, -1, 1'b0);
`ifdef GENIUS_LIVES_EN
    step(I_NONE);  chk("mis.replay", ST_PLAY_FPGA, 1, 1, -1, 1'b0);
    step(I_EFPGA); chk("mis.user2", ST_PLAY_USER, 1, 1, -1, 1'b0);
    step(I_EUSER); chk("mis.check2", ST_CHECK, 1, 1, -1, 1'b0);
    step(I_NONE);  chk("mis.miss2", ST_RESULT, 1, 0, 0, 1'b0);
`endif
    step(I_NONE);  chk("mis.hold", ST_RESULT, 1, 0, 0, 1'b0);

    // Reset during Play_FPGA of round 2
    goto_play_user("mrst");
    step(I_EUSER); chk("mrst.check", ST_CHECK, 1, 2, -1, 1'b0);
    step(I_MATCH); chk("mrst.next", ST_NEXT_ROUND, 1, 2, -1, 1'b0);
    step(I_NONE);  chk("mrst.fpga2", ST_PLAY_FPGA, 2, 2, -1, 1'b0);
    do_reset("mrst.reset");
    step(I_NONE);  chk("mrst.setup", ST_SETUP, 1, 2, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/genius_ctrl_p.md
GENIUS_CTRL_P -- requirements
Module: genius_ctrl_p

Interface
REQ-001 Parameters (name, default, meaning):
- NROUNDS, 32, rounds to win; legal range 1..255
- TIMEOUT_CYC, 50000000, idle cycles allowed in Play_User before timeout; at least 2
- LIVES, 3, failures tolerated before game over; at least 1; used only with GENIUS_LIVES_EN
REQ-002 RW = clog2(NROUNDS+1), TW = clog2(TIMEOUT_CYC), LW = clog2(LIVES+1).
REQ-003 Ports (name, direction, width, meaning); reset is synchronous, active-high; clock is CLOCK:
- CLOCK  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- enter  in  1  start/restart request, level
- end_FPGA  in  1  sequence playback done
- end_User  in  1  user entry of the current round done
- key_any  in  1  any user key press; restarts the timeout
- match  in  1  user entry equals the sequence; valid in Check
- R1, R2  out  1  datapath clears: full / round
- E1, E2, E3, E4  out  1  enables: setup / user / FPGA / compare
- SEL  out  1  display result
- round  out  RW  current round, 1-based
- lives  out  LW  remaining lives
- win  out  1  game won; valid while SEL=1
- timeout  out  1  1-cycle pulse when the timeout fires
- state_o  out  4  state encoding, for debug

Function
REQ-004 States: Init, Setup, Play_FPGA, Play_User, Check, Next_Round, Retry, Result. Transitions are evaluated once per rising CLOCK edge.
REQ-005 Init -> Setup unconditionally. Setup -> Play_FPGA when enter=1.
REQ-006 Play_FPGA -> Play_User when end_FPGA=1; otherwise stay.
REQ-007 Play_User: timeout -> Fail; else end_User -> Check; else stay. Timeout wins when both occur in the same cycle.
REQ-008 Check: match=1 -> Next_Round; match=0 -> Fail.
REQ-009 Next_Round: round==NROUNDS -> Result with win=1; else round increments and the FSM goes to Play_FPGA.
REQ-010 Fail, with the feature on: lives decrements; the FSM goes to Retry if the new value is >0, else to Result with win=0.
REQ-011 Retry -> Play_FPGA with round unchanged, so the same sequence replays.
REQ-012 Result: hold; enter=1 -> Init, which restarts the game. Outputs are unchanged in the hold state.
REQ-013 Moore outputs, decoded from the state register only. There is no combinational path from input to output.
REQ-014 Output decode:
- Init: R1=R2=1
- Setup: E1=1
- Play_FPGA: E3=1
- Play_User: E2=1
- Check: E4=1
- Next_Round: R2=1
- Retry: R2=1
- Result: SEL=1
- All other outputs are 0.
REQ-015 Timeout counter:
- Clears on entry to Play_User and on any cycle with key_any=1.
- Increments on every other Play_User cycle.
- Fires when it reaches TIMEOUT_CYC-1 with key_any=0.
- timeout=1 on the firing cycle only.
REQ-016 round saturates at NROUNDS and never wraps. lives never underflows below 0.
REQ-017 round is set to 1 and lives to LIVES in Init. win clears in Init.

Reset
REQ-018 reset=1 puts the FSM in Init, clears both counters, sets round=1, lives=LIVES and win=0. This applies in any state, mid-game included, and takes effect at the next edge.
REQ-019 Outputs during and right after reset follow the Init decode: R1=R2=1, all others 0.

Configuration
REQ-020 Macro GENIUS_LIVES_EN:
- Defined: lives and Retry behave per REQ-010/011.
- Undefined: any Fail goes directly to Result with win=0, Retry is unreachable, and lives is tied to 0.

Structure
REQ-021 Package genius_pkg holds:
- the state enum typedef and its 4-bit encodings
- the width helper (clog2)
- default parameter constants
REQ-022 Sub-module genius_timer (TW-bit timeout counter with clear/enable/fire) is instantiated once.

Verification
REQ-023 Bench parameters: NROUNDS=3, TIMEOUT_CYC=16, LIVES=2.
- Perfect game: enter, then 3× (end_FPGA, end_User, match=1) -> SEL=1, win=1, round=3.
- Timeout: in Play_User, hold key_any=0 for 16 cycles -> timeout pulses once, Retry entered, lives=1, round unchanged.
- Simultaneous events: end_User=1 on the timeout cycle -> Fail path taken, not Check.
- key_any pulse at count 14 -> counter clears, no timeout for 16 more cycles.
- Two mismatches -> lives 2→1→0, Result, win=0. With the macro undefined, the first mismatch goes directly to Result.
- Mid-game reset: reset in Play_FPGA at round 2 -> next cycle Init, round=1, R1=R2=1. Separately, enter in Result -> Init, then Setup.
